// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and FSM encodings for the inter-stage pipeline registers.
package pipe_stage_reg_pkg;

    // Stall vector bit meanings.
    localparam logic Stop    = 1'b1;
    localparam logic NoStop  = 1'b0;

    // Reset level for these blocks (active-low).
    localparam logic RstEnable = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Skid-buffer occupancy states.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_BUSY  = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

    // Default bubble payloads for the classic five-stage instantiations.
    localparam logic [127:0] NOP_ID_EX  = 128'h0;
    localparam logic [127:0] NOP_EX_MEM = 128'h0;
    localparam logic [127:0] NOP_MEM_WB = 128'h0;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter with asynchronous active-low reset.
module sat_counter16
    import pipe_stage_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: step by one unless already pinned at the maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: stall-vector latch (SKID=0) or 2-entry
// valid/ready skid buffer (SKID=1), both with flush and a bubble counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned        DATA_W   = 128,
    parameter int unsigned        STALL_W  = 6,
    parameter int unsigned        STAGE    = 2,
    parameter int unsigned        SKID     = 0,
    parameter logic [DATA_W-1:0]  NOP_DATA = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic [15:0]        bubble_cnt
);

    logic cnt_inc;

    // Each mode ignores one of these inputs; fold them so nothing dangles.
    logic unused_inputs;
    assign unused_inputs = ^{stall, out_ready};

    sat_counter16 u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .cnt (bubble_cnt)
    );

    if (SKID == 0) begin : g_stall
        logic              valid_q;
        logic              valid_d;
        logic [DATA_W-1:0] data_q;
        logic [DATA_W-1:0] data_d;
        logic              bubble;

        // Upstream stalled while downstream runs opens a gap: fill it with a NOP.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            bubble  = 1'b0;
            if (flush) begin
                valid_d = 1'b0;
                data_d  = NOP_DATA;
            end else if ((stall[STAGE] == Stop) && (stall[STAGE+1] == NoStop)) begin
                valid_d = 1'b0;
                data_d  = NOP_DATA;
                bubble  = 1'b1;
            end else if (stall[STAGE] == NoStop) begin
                valid_d = in_valid;
                data_d  = in_data;
            end
        end

        // Output latch.
        always_ff @(posedge clk or negedge rst) begin
            if (rst == RstEnable) begin
                valid_q <= 1'b0;
                data_q  <= NOP_DATA;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign in_ready  = ~stall[STAGE];
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign cnt_inc   = bubble;
    end else begin : g_skid
        skid_state_e       state_q;
        skid_state_e       state_d;
        logic [DATA_W-1:0] m_data_q;
        logic [DATA_W-1:0] m_data_d;
        logic [DATA_W-1:0] s_data_q;
        logic [DATA_W-1:0] s_data_d;
        logic              rdy_q;
        logic              rdy_d;
        logic              push;
        logic              pop;

        // in_ready comes from a flop so the upstream path never sees out_ready.
        assign push = in_valid & rdy_q;
        assign pop  = (state_q != SKID_EMPTY) & out_ready;

        // Occupancy FSM; M always holds the oldest entry, S the overflow.
        always_comb begin
            state_d  = state_q;
            m_data_d = m_data_q;
            s_data_d = s_data_q;
            if (flush) begin
                state_d  = SKID_EMPTY;
                m_data_d = NOP_DATA;
                s_data_d = NOP_DATA;
            end else begin
                case (state_q)
                    SKID_EMPTY: begin
                        if (push) begin
                            state_d  = SKID_BUSY;
                            m_data_d = in_data;
                        end
                    end
                    SKID_BUSY: begin
                        if (push && !pop) begin
                            state_d  = SKID_FULL;
                            s_data_d = in_data;
                        end else if (push && pop) begin
                            m_data_d = in_data;
                        end else if (pop) begin
                            state_d  = SKID_EMPTY;
                        end
                    end
                    SKID_FULL: begin
                        if (pop) begin
                            state_d  = SKID_BUSY;
                            m_data_d = s_data_q;
                        end
                    end
                    default: begin
                        state_d  = SKID_EMPTY;
                        m_data_d = NOP_DATA;
                    end
                endcase
            end
            rdy_d = (state_d != SKID_FULL);
        end

        // State, storage and ready registers.
        always_ff @(posedge clk or negedge rst) begin
            if (rst == RstEnable) begin
                state_q  <= SKID_EMPTY;
                m_data_q <= NOP_DATA;
                s_data_q <= NOP_DATA;
                rdy_q    <= 1'b1;
            end else begin
                state_q  <= state_d;
                m_data_q <= m_data_d;
                s_data_q <= s_data_d;
                rdy_q    <= rdy_d;
            end
        end

        assign in_ready  = rdy_q;
        assign out_valid = (state_q != SKID_EMPTY);
        assign out_data  = m_data_q;
        assign cnt_inc   = (state_q == SKID_FULL);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one stall-vector instance and one skid-buffer instance.
module tb_pipe_stage_reg;

    localparam logic [127:0] NOP0 = 128'h0000_0000_0000_0000_0000_0000_0000_0013;
    localparam logic [127:0] NOP1 = 128'hC0DE_0000_0000_0000_0000_0000_0000_BEEF;
    localparam logic [5:0]   HOLD = 6'b001100;
    localparam logic [5:0]   BUBL = 6'b000100;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [5:0]   stall0    = HOLD;
    logic         flush0    = 1'b0;
    logic         in_valid0 = 1'b0;
    logic [127:0] in_data0  = '0;
    logic         in_ready0;
    logic         out_valid0;
    logic [127:0] out_data0;
    logic         out_ready0 = 1'b0;
    logic [15:0]  bubble_cnt0;

    logic [5:0]   stall1    = '0;
    logic         flush1    = 1'b0;
    logic         in_valid1 = 1'b0;
    logic [127:0] in_data1  = '0;
    logic         in_ready1;
    logic         out_valid1;
    logic [127:0] out_data1;
    logic         out_ready1 = 1'b0;
    logic [15:0]  bubble_cnt1;

    int errors = 0;
    int checks = 0;

    // Stall-mode reference model.
    logic         exp_v0   = 1'b0;
    logic [127:0] exp_d0   = NOP0;
    logic [15:0]  exp_cnt0 = 16'h0;

    // Skid-mode scoreboard and reference state.
    logic [127:0] sb[$];
    logic [15:0]  exp_cnt1 = 16'h0;
    logic         nop_exp1 = 1'b1;
    int           pops     = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(128), .STALL_W(6), .STAGE(2), .SKID(0), .NOP_DATA(NOP0)
    ) dut0 (
        .clk(clk), .rst(rst), .stall(stall0), .flush(flush0),
        .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready0),
        .bubble_cnt(bubble_cnt0)
    );

    pipe_stage_reg #(
        .DATA_W(128), .STALL_W(6), .STAGE(2), .SKID(1), .NOP_DATA(NOP1)
    ) dut1 (
        .clk(clk), .rst(rst), .stall(stall1), .flush(flush1),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
        .bubble_cnt(bubble_cnt1)
    );

    // One stall-mode cycle: drive, predict, then compare after the edge.
    task automatic stall_cycle(input logic [5:0] st, input logic vld,
                               input logic [127:0] d, input logic fl);
        @(negedge clk);
        stall0 = st; in_valid0 = vld; in_data0 = d; flush0 = fl;
        #1;
        checks++;
        if (in_ready0 !== ~st[2]) begin
            errors++;
            $display("FAIL s0_in_ready: got %b expected %b", in_ready0, ~st[2]);
        end
        if (fl) begin
            exp_v0 = 1'b0; exp_d0 = NOP0;
        end else if (st[2] && !st[3]) begin
            exp_v0 = 1'b0; exp_d0 = NOP0;
            if (exp_cnt0 != 16'hFFFF) exp_cnt0 = exp_cnt0 + 16'd1;
        end else if (!st[2]) begin
            exp_v0 = vld; exp_d0 = d;
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid0 !== exp_v0) begin
            errors++;
            $display("FAIL s0_out_valid: got %b expected %b", out_valid0, exp_v0);
        end
        checks++;
        if (out_data0 !== exp_d0) begin
            errors++;
            $display("FAIL s0_out_data: got %h expected %h", out_data0, exp_d0);
        end
        checks++;
        if (bubble_cnt0 !== exp_cnt0) begin
            errors++;
            $display("FAIL s0_bubble_cnt: got %h expected %h", bubble_cnt0, exp_cnt0);
        end
        $display("s0 cycle stall=%b vld=%b flush=%b -> v=%b d=%h cnt=%0d",
                 st, vld, fl, out_valid0, out_data0, bubble_cnt0);
    endtask

    // One skid-mode cycle: drive, check status against occupancy, score push/pop.
    task automatic skid_cycle(input logic vld, input logic [127:0] d,
                              input logic ordy, input logic fl);
        int   occ;
        logic exp_rdy;
        logic push;
        logic pop;
        @(negedge clk);
        in_valid1 = vld; in_data1 = d; out_ready1 = ordy; flush1 = fl;
        #1;
        occ     = sb.size();
        exp_rdy = (occ != 2);
        checks++;
        if (in_ready1 !== exp_rdy) begin
            errors++;
            $display("FAIL s1_in_ready: got %b expected %b", in_ready1, exp_rdy);
        end
        checks++;
        if (out_valid1 !== (occ != 0)) begin
            errors++;
            $display("FAIL s1_out_valid: got %b expected %b", out_valid1, (occ != 0));
        end
        checks++;
        if (bubble_cnt1 !== exp_cnt1) begin
            errors++;
            $display("FAIL s1_bubble_cnt: got %h expected %h", bubble_cnt1, exp_cnt1);
        end
        if (occ == 0 && nop_exp1) begin
            checks++;
            if (out_data1 !== NOP1) begin
                errors++;
                $display("FAIL s1_nop_data: got %h expected %h", out_data1, NOP1);
            end
        end
        push = vld && exp_rdy;
        pop  = (occ != 0) && ordy;
        if (pop) begin
            checks++;
            if (out_data1 !== sb[0]) begin
                errors++;
                $display("FAIL s1_pop_data: got %h expected %h", out_data1, sb[0]);
            end
            void'(sb.pop_front());
            pops++;
        end
        if (fl) begin
            sb.delete();
            nop_exp1 = 1'b1;
        end else if (push) begin
            sb.push_back(d);
            nop_exp1 = 1'b0;
        end
        if (occ == 2 && exp_cnt1 != 16'hFFFF) exp_cnt1 = exp_cnt1 + 16'd1;
        $display("s1 cycle vld=%b ordy=%b flush=%b occ=%0d push=%b pop=%b d=%h",
                 vld, ordy, fl, occ, push, pop, out_data1);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid0 !== 1'b0 || out_data0 !== NOP0 || bubble_cnt0 !== 16'h0) begin
            errors++;
            $display("FAIL rst_s0: got v=%b d=%h cnt=%h expected 0/%h/0",
                     out_valid0, out_data0, bubble_cnt0, NOP0);
        end
        checks++;
        if (in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_s0_ready_stalled: got %b expected 0", in_ready0);
        end
        stall0 = 6'b000000;
        #1;
        checks++;
        if (in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_s0_ready_free: got %b expected 1", in_ready0);
        end
        stall0 = HOLD;
        checks++;
        if (out_valid1 !== 1'b0 || out_data1 !== NOP1 || in_ready1 !== 1'b1 || bubble_cnt1 !== 16'h0) begin
            errors++;
            $display("FAIL rst_s1: got v=%b d=%h rdy=%b cnt=%h", out_valid1, out_data1, in_ready1, bubble_cnt1);
        end
        $display("reset state checked");
        @(negedge clk);
        rst = 1'b1;

        // Fill the skid buffer, then pull reset between clock edges.
        skid_cycle(1'b1, {{15{8'hA5}}, 8'h01}, 1'b0, 1'b0);
        skid_cycle(1'b1, {{15{8'hA5}}, 8'h02}, 1'b0, 1'b0);
        skid_cycle(1'b1, {{15{8'hA5}}, 8'h03}, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid1 !== 1'b0 || out_data1 !== NOP1 || in_ready1 !== 1'b1 || bubble_cnt1 !== 16'h0) begin
            errors++;
            $display("FAIL async_rst_s1: got v=%b d=%h rdy=%b cnt=%h", out_valid1, out_data1, in_ready1, bubble_cnt1);
        end
        $display("async reset mid-stream: v=%b d=%h rdy=%b", out_valid1, out_data1, in_ready1);
        @(negedge clk);
        in_valid1 = 1'b0; out_ready1 = 1'b0; flush1 = 1'b0;
        rst = 1'b1;
        sb.delete();
        exp_cnt1 = 16'h0;
        nop_exp1 = 1'b1;
    endtask

    task automatic test_stall_bubbles();
        stall_cycle(6'b000000, 1'b1, 128'h55, 1'b0);
        stall_cycle(HOLD,      1'b1, 128'h66, 1'b0);
        stall_cycle(HOLD,      1'b1, 128'h66, 1'b0);
        for (int i = 0; i < 3; i++) stall_cycle(BUBL, 1'b1, 128'h77, 1'b0);
        checks++;
        if (bubble_cnt0 !== 16'd3) begin
            errors++;
            $display("FAIL three_bubbles: got %0d expected 3", bubble_cnt0);
        end
        stall_cycle(HOLD,        1'b1, 128'h88,   1'b0);
        stall_cycle(6'b000000,   1'b1, 128'h1234, 1'b0);
        stall_cycle(6'b001000,   1'b1, 128'hAB,   1'b0);
        stall_cycle(6'b000000,   1'b0, 128'h99,   1'b0);
        stall_cycle(HOLD,        1'b0, 128'h0,    1'b0);
    endtask

    task automatic test_backpressure();
        int p0;
        p0 = pops;
        skid_cycle(1'b1, 128'h11, 1'b0, 1'b0);
        skid_cycle(1'b1, 128'h22, 1'b0, 1'b0);
        skid_cycle(1'b1, 128'h33, 1'b0, 1'b0);
        checks++;
        if (in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready: got %b expected 0", in_ready1);
        end
        skid_cycle(1'b1, 128'h33, 1'b0, 1'b0);
        skid_cycle(1'b1, 128'h33, 1'b1, 1'b0);
        skid_cycle(1'b1, 128'h33, 1'b1, 1'b0);
        skid_cycle(1'b0, 128'h0,  1'b1, 1'b0);
        skid_cycle(1'b0, 128'h0,  1'b0, 1'b0);
        checks++;
        if (pops - p0 != 3 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got pops=%0d left=%0d expected 3/0", pops - p0, sb.size());
        end
        checks++;
        if (bubble_cnt1 !== 16'd3) begin
            errors++;
            $display("FAIL bp_full_cycles: got %0d expected 3", bubble_cnt1);
        end
    endtask

    task automatic test_streaming();
        int          p0;
        logic [15:0] c0;
        p0 = pops;
        c0 = exp_cnt1;
        for (int i = 0; i < 100; i++) skid_cycle(1'b1, 128'h1000 + 128'(i), 1'b1, 1'b0);
        skid_cycle(1'b0, 128'h0, 1'b1, 1'b0);
        skid_cycle(1'b0, 128'h0, 1'b0, 1'b0);
        checks++;
        if (pops - p0 != 100) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 100", pops - p0);
        end
        checks++;
        if (bubble_cnt1 !== c0) begin
            errors++;
            $display("FAIL stream_no_full: got %0d expected %0d", bubble_cnt1, c0);
        end
    endtask

    task automatic test_flush();
        skid_cycle(1'b1, 128'h501, 1'b0, 1'b0);
        skid_cycle(1'b1, 128'h502, 1'b0, 1'b0);
        skid_cycle(1'b1, 128'h503, 1'b1, 1'b1);
        skid_cycle(1'b0, 128'h0,   1'b0, 1'b0);
        skid_cycle(1'b0, 128'h0,   1'b1, 1'b0);
        skid_cycle(1'b1, 128'h700, 1'b0, 1'b0);
        skid_cycle(1'b1, 128'h701, 1'b1, 1'b1);
        skid_cycle(1'b0, 128'h0,   1'b1, 1'b0);
        skid_cycle(1'b1, 128'h800, 1'b1, 1'b0);
        skid_cycle(1'b0, 128'h0,   1'b1, 1'b0);
        skid_cycle(1'b0, 128'h0,   1'b0, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL flush_leftover: got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut0.u_bubble_cnt.cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut0.u_bubble_cnt.cnt_q;
        exp_cnt0 = 16'hFFFE;
        @(negedge clk);
        checks++;
        if (bubble_cnt0 !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload: got %h expected fffe", bubble_cnt0);
        end
        for (int i = 0; i < 3; i++) stall_cycle(BUBL, 1'b1, 128'h42, 1'b0);
        stall_cycle(6'b000000, 1'b1, 128'h43, 1'b1);
        stall_cycle(HOLD,      1'b0, 128'h0,  1'b0);
        checks++;
        if (bubble_cnt0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_after_flush: got %h expected ffff", bubble_cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_stall_bubbles();
        test_backpressure();
        test_streaming();
        test_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
